mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store sequencer that sits directly downstream of the controller. It takes one memory request
//   per handshake (lb/lh/lw/lbu/lhu, sb/sh/sw) and drives the single-outstanding memory bus. It holds
//   the request until mem_ack and performs byte-lane selection plus sign/zero extension.
//   The completed load word, or the store completion, is returned to the controller's messReg path
//   through a valid/ready response port.
// PARAMETERS
//   TIMEOUT   256  cycles waited for mem_ack before aborting with rsp_err (>=2)
//   CNT_W     9    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   unit can accept request (high only in IDLE)
//   req_store    in   1   0 = load (op 001), 1 = store (op 010)
//   req_funct    in   4   0001 b, 0010 h, 0011 w; loads also 0100 bu, 0101 hu
//   req_addr     in   32  byte address (opA+opB from controller)
//   req_wdata    in   32  store data; low byte/half/word used per funct
//   mem_read     out  1   read strobe, held until ack
//   mem_write    out  1   write strobe, held until ack
//   mem_address  out  32  word-aligned address {req_addr[31:2],2'b00}
//   mem_wdata    out  32  store data replicated to all lanes (byte x4, half x2)
//   mem_be       out  4   byte enables, bit i = byte lane i (little-endian)
//   mem_ack      in   1   one-cycle completion pulse from memory
//   mem_message  in   32  read data, valid in the mem_ack cycle
//   rsp_valid    out  1   response available
//   rsp_ready    in   1   consumer takes response
//   rsp_data     out  32  extended load data; 0 for stores and errors
//   rsp_err      out  1   misaligned, illegal funct, or timeout
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   Reset: state IDLE. All outputs 0 except req_ready=1. Counter 0, all latches 0.
//   Reset mid-transaction abandons the request; no response is issued.
//   FSM IDLE -> BUS -> RESP -> IDLE.
//   IDLE
//     - req_ready=1; accept on req_valid&req_ready; latch addr, wdata, funct, store.
//     - Legal, aligned request -> BUS.
//     - Illegal funct (loads outside 0001-0101, stores outside 0001-0011) -> RESP with rsp_err=1,
//       no bus activity.
//     - Misaligned access (h with addr[0]=1, w with addr[1:0]!=0) -> same as illegal funct.
//   BUS
//     - mem_read or mem_write=1 from the cycle after accept; mem_address, mem_be, mem_wdata stable.
//     - mem_ack sampled high: capture mem_message, drop the strobe next cycle, -> RESP.
//     - Timeout counter increments each BUS cycle without ack. At TIMEOUT-1 with no ack:
//       -> RESP with rsp_err=1. A late ack after abort is ignored.
//     - mem_ack outside BUS is ignored.
//   RESP
//     - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready.
//     - On rsp_valid&rsp_ready: -> IDLE. req_ready rises the following cycle (no bypass).
//   Minimum latency: accept at cycle N, strobe at N+1, ack at N+1 gives rsp_valid at N+2.
//   Lane select, s = addr[1:0]
//     - b: byte = mem_message[8s+7:8s], be = 1<<s.
//     - h: half = mem_message[16s/2*... ] i.e. addr[1]?[31:16]:[15:0], be = addr[1]?1100:0011.
//     - w: be = 1111.
//   Extension: lb and lh sign-extend from the selected byte/half's own MSB (bit 7/15 of the lane),
//   never from mem_message[31]. lbu and lhu zero-extend. lw passes through.
//   Stores return rsp_data=0, rsp_err=0.
// TESTING
//   1. lb addr=0x103, mem_message=0x80FF_1234, ack 1 cycle later
//      -> mem_address=0x100, be=1000, rsp_data=0xFFFFFF80.
//   2. lhu addr=0x22, mem_message=0xBEEF_0001
//      -> rsp_data=0x0000BEEF; lh same input -> 0xFFFFBEEF.
//   3. sb addr=0x41, wdata=0x0000_00A5
//      -> mem_write=1, be=0010, mem_wdata=0xA5A5A5A5, rsp_data=0, rsp_err=0.
//   4. lw addr=0x6, or req_funct=0111 load
//      -> no mem strobe, rsp_err=1 the cycle after accept.
//   5. lw, mem_ack never asserted
//      -> strobe held exactly TIMEOUT cycles, then rsp_err=1.
//      Late ack in RESP leaves rsp_data unchanged.
//   6. rsp_ready held low 5 cycles
//      -> rsp_valid/rsp_data stable, req_ready=0. Assert rst_n=0 mid-BUS -> strobes 0 immediately.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//   Bundles the three handshakes of the load/store sequencer: the request port
//   from the controller, the single-outstanding memory bus and the response
//   port back to the controller's messReg path.
//
//   Modports
//     master : the access unit itself. It accepts requests, drives the memory
//              bus and produces responses.
//     slave  : the surroundings (controller plus memory model) that drive
//              requests, memory acks/data and response back-pressure.
//
//   Signals
//     req_valid/req_ready       request handshake
//     req_store, req_funct      operation (load/store, size/extension)
//     req_addr, req_wdata       byte address and store data
//     mem_read/mem_write        strobes, held until mem_ack
//     mem_address, mem_be       word-aligned address, byte-lane enables
//     mem_wdata                 lane-replicated store data
//     mem_ack, mem_message      one-cycle completion and read data
//     rsp_valid/rsp_ready       response handshake
//     rsp_data, rsp_err         extended load data, error flag
//     busy                      unit is not idle
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [3:0]  req_funct;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_message;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   logic        busy;

   modport master (
      input  req_valid, req_store, req_funct, req_addr, req_wdata,
      output req_ready,
      output mem_read, mem_write, mem_address, mem_wdata, mem_be,
      input  mem_ack, mem_message,
      output rsp_valid, rsp_data, rsp_err,
      input  rsp_ready,
      output busy
   );

   modport slave (
      output req_valid, req_store, req_funct, req_addr, req_wdata,
      input  req_ready,
      input  mem_read, mem_write, mem_address, mem_wdata, mem_be,
      output mem_ack, mem_message,
      input  rsp_valid, rsp_data, rsp_err,
      output rsp_ready,
      input  busy
   );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store sequencer placed directly after the controller. It takes one
//   request per handshake (lb/lh/lw/lbu/lhu, sb/sh/sw) and runs it on a
//   single-outstanding memory bus. Byte-lane enables and replicated store
//   data are generated on accept. Load data is lane-selected and sign or zero
//   extended when mem_ack arrives. The result goes back through a valid/ready
//   response port.
//
//   Parameters
//     TIMEOUT : BUS cycles to wait for mem_ack before aborting with rsp_err
//     CNT_W   : timeout counter width, 2**CNT_W > TIMEOUT
//
//   Ports
//     clk   : clock, all state changes on the rising edge
//     rst_n : asynchronous active-low reset; abandons any transaction in flight
//     mif   : mem_access_unit_if.master (request, memory bus, response, busy)
//
//   Every output is a register. The FSM runs IDLE -> BUS -> RESP -> IDLE.
//   Illegal or misaligned requests go straight from IDLE to RESP with rsp_err
//   and cause no bus activity.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.master mif
);

   // funct encodings shared by loads and stores (bu/hu are load-only)
   localparam logic [3:0] F_B  = 4'b0001;
   localparam logic [3:0] F_H  = 4'b0010;
   localparam logic [3:0] F_W  = 4'b0011;
   localparam logic [3:0] F_BU = 4'b0100;
   localparam logic [3:0] F_HU = 4'b0101;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             store_q;
   logic [3:0]       funct_q;
   logic [1:0]       addr_lo_q;

   // Legal funct for the direction, with natural alignment for the size.
   function automatic logic is_legal(input logic       store,
                                     input logic [3:0] funct,
                                     input logic [1:0] lo);
      logic ok;
      ok = 1'b0;
      case (funct)
         F_B:     ok = 1'b1;
         F_H:     ok = ~lo[0];
         F_W:     ok = (lo == 2'b00);
         F_BU:    ok = ~store;
         F_HU:    ok = ~store & ~lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables, bit i = byte lane i (little-endian).
   function automatic logic [3:0] lane_be(input logic [3:0] funct,
                                          input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (funct)
         F_B, F_BU: be = 4'b0001 << lo;
         F_H, F_HU: be = lo[1] ? 4'b1100 : 4'b0011;
         F_W:       be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data is copied onto every lane so memory can take whichever lane
   // mem_be enables, without needing to know the address offset.
   function automatic logic [31:0] store_lanes(input logic [3:0]  funct,
                                               input logic [31:0] wdata);
      logic [31:0] d;
      d = wdata;
      case (funct)
         F_B:     d = {4{wdata[7:0]}};
         F_H:     d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   // Lane select plus extension. The sign comes from the selected lane's own
   // MSB, never from mem_message[31].
   function automatic logic [31:0] load_extend(input logic [3:0]  funct,
                                               input logic [1:0]  lo,
                                               input logic [31:0] msg);
      logic [7:0]  byte_lane;
      logic [15:0] half_lane;
      logic [31:0] d;
      byte_lane = msg[{lo, 3'b000} +: 8];
      half_lane = lo[1] ? msg[31:16] : msg[15:0];
      d         = 32'h0;
      case (funct)
         F_B:     d = {{24{byte_lane[7]}}, byte_lane};
         F_BU:    d = {24'h0, byte_lane};
         F_H:     d = {{16{half_lane[15]}}, half_lane};
         F_HU:    d = {16'h0, half_lane};
         F_W:     d = msg;
         default: d = 32'h0;
      endcase
      return d;
   endfunction

   // NOTE: sequential state uses non-blocking assignments, so every branch
   // below sees register values from before the edge, whatever the statement
   // order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         store_q         <= 1'b0;
         funct_q         <= 4'h0;
         addr_lo_q       <= 2'b00;
         mif.req_ready   <= 1'b1;
         mif.mem_read    <= 1'b0;
         mif.mem_write   <= 1'b0;
         mif.mem_address <= 32'h0;
         mif.mem_wdata   <= 32'h0;
         mif.mem_be      <= 4'h0;
         mif.rsp_valid   <= 1'b0;
         mif.rsp_data    <= 32'h0;
         mif.rsp_err     <= 1'b0;
         mif.busy        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // req_ready is high throughout IDLE, so req_valid alone accepts.
               if (mif.req_valid) begin
                  store_q       <= mif.req_store;
                  funct_q       <= mif.req_funct;
                  addr_lo_q     <= mif.req_addr[1:0];
                  mif.req_ready <= 1'b0;
                  mif.busy      <= 1'b1;
                  cnt           <= '0;
                  if (is_legal(mif.req_store, mif.req_funct, mif.req_addr[1:0])) begin
                     state           <= S_BUS;
                     mif.mem_read    <= ~mif.req_store;
                     mif.mem_write   <= mif.req_store;
                     mif.mem_address <= {mif.req_addr[31:2], 2'b00};
                     mif.mem_be      <= lane_be(mif.req_funct, mif.req_addr[1:0]);
                     mif.mem_wdata   <= mif.req_store
                                        ? store_lanes(mif.req_funct, mif.req_wdata)
                                        : 32'h0;
                  end else begin
                     state         <= S_RESP;
                     mif.rsp_valid <= 1'b1;
                     mif.rsp_err   <= 1'b1;
                     mif.rsp_data  <= 32'h0;
                  end
               end
            end

            S_BUS: begin
               // An ack in the last counted cycle still wins over the timeout.
               if (mif.mem_ack) begin
                  state         <= S_RESP;
                  mif.mem_read  <= 1'b0;
                  mif.mem_write <= 1'b0;
                  mif.rsp_valid <= 1'b1;
                  mif.rsp_err   <= 1'b0;
                  mif.rsp_data  <= store_q ? 32'h0
                                           : load_extend(funct_q, addr_lo_q, mif.mem_message);
               end else if (cnt == CNT_LAST) begin
                  state         <= S_RESP;
                  mif.mem_read  <= 1'b0;
                  mif.mem_write <= 1'b0;
                  mif.rsp_valid <= 1'b1;
                  mif.rsp_err   <= 1'b1;
                  mif.rsp_data  <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RESP: begin
               // The response is held until taken; mem_ack is ignored here.
               if (mif.rsp_ready) begin
                  state         <= S_IDLE;
                  mif.rsp_valid <= 1'b0;
                  mif.rsp_err   <= 1'b0;
                  mif.rsp_data  <= 32'h0;
                  mif.req_ready <= 1'b1;
                  mif.busy      <= 1'b0;
               end
            end

            default: begin
               state         <= S_IDLE;
               mif.req_ready <= 1'b1;
               mif.mem_read  <= 1'b0;
               mif.mem_write <= 1'b0;
               mif.rsp_valid <= 1'b0;
               mif.busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit. Inputs are driven and outputs are
//   sampled on the falling clock edge. Expected values come from a reference
//   model that uses plain arithmetic on the access rules (shift, mask, signed
//   wrap).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int TIMEOUT = 256;
   localparam int CNT_W   = 9;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mem_access_unit_if mif ();

   mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mif   (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int access_size(input logic [3:0] funct);
      case (funct)
         4'd1, 4'd4: return 1;
         4'd2, 4'd5: return 2;
         4'd3:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic model_legal(input logic store, input logic [3:0] funct,
                                        input logic [31:0] addr);
      int sz;
      sz = access_size(funct);
      if (sz == 0) return 1'b0;
      if (store && funct > 4'd3) return 1'b0;
      return (addr % sz) == 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [3:0] funct, input logic [31:0] addr);
      int sz;
      sz = access_size(funct);
      if (sz == 1) return 4'(1 << (addr % 4));
      if (sz == 2) return 4'(3 << (addr % 4));
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [3:0] funct, input logic [31:0] wd);
      int sz;
      sz = access_size(funct);
      if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [3:0] funct, input logic [31:0] addr,
                                              input logic [31:0] msg);
      logic [31:0] v;
      v = msg >> (8 * (addr % 4));
      case (funct)
         4'd1: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
         4'd4:       v = v & 32'hFF;
         4'd2: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
         4'd5:       v = v & 32'hFFFF;
         default:    v = msg;
      endcase
      return v;
   endfunction

   // ---------------- one full transaction, checked against the model ----------------
   task automatic run_txn(input logic store, input logic [3:0] funct, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] msg,
                          input int ack_dly, input int rsp_dly, input string tag);
      logic        legal;
      logic        e_err;
      logic [31:0] e_data;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      int          n;
      legal  = model_legal(store, funct, addr);
      e_err  = ~legal;
      e_data = (legal && !store) ? model_load(funct, addr, msg) : 32'h0;
      e_be   = model_be(funct, addr);
      e_wd   = store ? model_wdata(funct, wdata) : 32'h0;

      n = 0;
      while (!mif.req_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (mif.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_wait: req_ready=%b required 1", tag, mif.req_ready);
      end

      mif.req_valid = 1'b1;
      mif.req_store = store;
      mif.req_funct = funct;
      mif.req_addr  = addr;
      mif.req_wdata = wdata;
      @(negedge clk);
      // Scramble request fields after accept; the unit must use its latches.
      mif.req_valid = 1'b0;
      mif.req_store = 1'($urandom);
      mif.req_funct = 4'($urandom);
      mif.req_addr  = $urandom;
      mif.req_wdata = $urandom;

      if (!legal) begin
         checks++;
         if ({mif.mem_read, mif.mem_write, mif.rsp_valid, mif.rsp_err, mif.rsp_data}
             !== {1'b0, 1'b0, 1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL %s illegal: rd=%b wr=%b vld=%b err=%b data=%h required 0 0 1 1 00000000",
                     tag, mif.mem_read, mif.mem_write, mif.rsp_valid, mif.rsp_err, mif.rsp_data);
         end
      end else begin
         for (int i = 0; i <= ack_dly; i++) begin
            checks++;
            if ({mif.mem_read, mif.mem_write, mif.mem_address, mif.mem_be,
                 (store ? mif.mem_wdata : 32'h0), mif.rsp_valid}
                !== {~store, store, addr & 32'hFFFF_FFFC, e_be, e_wd, 1'b0}) begin
               errors++;
               $display("FAIL %s bus[%0d]: rd=%b wr=%b adr=%h be=%b wd=%h vld=%b required %b %b %h %b %h 0",
                        tag, i, mif.mem_read, mif.mem_write, mif.mem_address, mif.mem_be,
                        mif.mem_wdata, mif.rsp_valid, ~store, store, addr & 32'hFFFF_FFFC,
                        e_be, e_wd);
            end
            if (i == ack_dly) begin
               mif.mem_ack     = 1'b1;
               mif.mem_message = msg;
            end
            @(negedge clk);
         end
         mif.mem_ack     = 1'b0;
         mif.mem_message = $urandom;
         checks++;
         if ({mif.mem_read, mif.mem_write, mif.rsp_valid, mif.rsp_err, mif.rsp_data}
             !== {1'b0, 1'b0, 1'b1, 1'b0, e_data}) begin
            errors++;
            $display("FAIL %s response: rd=%b wr=%b vld=%b err=%b data=%h required 0 0 1 0 %h",
                     tag, mif.mem_read, mif.mem_write, mif.rsp_valid, mif.rsp_err,
                     mif.rsp_data, e_data);
         end
      end

      // Back-pressure with stray acks: response must stay frozen.
      for (int i = 0; i < rsp_dly; i++) begin
         mif.mem_ack     = 1'($urandom);
         mif.mem_message = $urandom;
         @(negedge clk);
         checks++;
         if ({mif.rsp_valid, mif.rsp_err, mif.rsp_data, mif.req_ready, mif.busy,
              mif.mem_read, mif.mem_write}
             !== {1'b1, e_err, e_data, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s hold[%0d]: vld=%b err=%b data=%h rdy=%b busy=%b required 1 %b %h 0 1",
                     tag, i, mif.rsp_valid, mif.rsp_err, mif.rsp_data, mif.req_ready,
                     mif.busy, e_err, e_data);
         end
      end
      mif.mem_ack   = 1'b0;
      mif.rsp_ready = 1'b1;
      @(negedge clk);
      mif.rsp_ready = 1'b0;
      checks++;
      if ({mif.rsp_valid, mif.req_ready, mif.busy} !== {1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s release: vld=%b rdy=%b busy=%b required 0 1 0",
                  tag, mif.rsp_valid, mif.req_ready, mif.busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({mif.req_ready, mif.mem_read, mif.mem_write, mif.mem_address, mif.mem_wdata,
           mif.mem_be, mif.rsp_valid, mif.rsp_data, mif.rsp_err, mif.busy}
          !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b rd=%b wr=%b adr=%h wd=%h be=%b vld=%b data=%h err=%b busy=%b required 1 and all others 0",
                  mif.req_ready, mif.mem_read, mif.mem_write, mif.mem_address, mif.mem_wdata,
                  mif.mem_be, mif.rsp_valid, mif.rsp_data, mif.rsp_err, mif.busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_txn(1'b0, 4'd1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, 0, "lb_0x103");
      checks++;
      if (model_load(4'd1, 32'h103, 32'h80FF_1234) !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL model_lb: got %h required FFFFFF80", model_load(4'd1, 32'h103, 32'h80FF_1234));
      end
      run_txn(1'b0, 4'd5, 32'h0000_0022, 32'h0, 32'hBEEF_0001, 0, 0, "lhu_0x22");
      run_txn(1'b0, 4'd2, 32'h0000_0022, 32'h0, 32'hBEEF_0001, 0, 0, "lh_0x22");
      run_txn(1'b1, 4'd1, 32'h0000_0041, 32'h0000_00A5, 32'h0, 2, 0, "sb_0x41");
      run_txn(1'b0, 4'd3, 32'h0000_0006, 32'h0, 32'h0, 0, 0, "lw_misaligned");
      run_txn(1'b0, 4'd7, 32'h0000_0100, 32'h0, 32'h0, 0, 0, "load_funct7");
      run_txn(1'b1, 4'd4, 32'h0000_0100, 32'h1234_5678, 32'h0, 0, 0, "store_funct4");
      run_txn(1'b1, 4'd2, 32'h0000_0203, 32'h1234_5678, 32'h0, 0, 0, "sh_misaligned");
      run_txn(1'b1, 4'd3, 32'h0000_0208, 32'hCAFE_F00D, 32'h0, 1, 5, "sw_hold5");
   endtask

   task automatic test_back_to_back();
      // Minimum latency path, issued as soon as req_ready returns.
      for (int i = 0; i < 6; i++)
         run_txn(1'b0, 4'd3, $urandom & 32'hFFFF_FFFC, 32'h0, $urandom, 0, 0, "b2b_lw");
   endtask

   task automatic test_random();
      logic        st;
      logic [3:0]  fn;
      logic [31:0] ad;
      for (int i = 0; i < 60; i++) begin
         st = 1'($urandom);
         fn = 4'($urandom_range(0, 7));
         ad = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (access_size(fn) == 2) ad = ad & 32'hFFFF_FFFE;
            if (access_size(fn) == 4) ad = ad & 32'hFFFF_FFFC;
         end
         run_txn(st, fn, ad, $urandom, $urandom, $urandom_range(0, 4),
                 $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_timeout();
      int held;
      mif.req_valid = 1'b1;
      mif.req_store = 1'b0;
      mif.req_funct = 4'd3;
      mif.req_addr  = 32'h0000_0400;
      @(negedge clk);
      mif.req_valid = 1'b0;
      held = 0;
      while (mif.mem_read && held < 1000) begin
         held++;
         @(negedge clk);
      end
      checks++;
      if (held != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_len: strobe held %0d cycles required %0d", held, TIMEOUT);
      end
      checks++;
      if ({mif.rsp_valid, mif.rsp_err, mif.rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL timeout_rsp: vld=%b err=%b data=%h required 1 1 00000000",
                  mif.rsp_valid, mif.rsp_err, mif.rsp_data);
      end
      mif.mem_ack     = 1'b1;
      mif.mem_message = 32'h8765_4321;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({mif.rsp_valid, mif.rsp_err, mif.rsp_data, mif.mem_read} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL late_ack: vld=%b err=%b data=%h rd=%b required 1 1 00000000 0",
                  mif.rsp_valid, mif.rsp_err, mif.rsp_data, mif.mem_read);
      end
      mif.rsp_ready = 1'b1;
      @(negedge clk);
      mif.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_bus();
      mif.req_valid = 1'b1;
      mif.req_store = 1'b1;
      mif.req_funct = 4'd3;
      mif.req_addr  = 32'h0000_0500;
      mif.req_wdata = 32'h1111_2222;
      @(negedge clk);
      mif.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mif.mem_read, mif.mem_write, mif.busy, mif.req_ready, mif.rsp_valid}
          !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_bus: rd=%b wr=%b busy=%b rdy=%b vld=%b required 0 0 0 1 0",
                  mif.mem_read, mif.mem_write, mif.busy, mif.req_ready, mif.rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // An ack after the abandoned request, and in IDLE, must produce nothing.
      mif.mem_ack = 1'b1;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mif.rsp_valid, mif.mem_write, mif.busy, mif.req_ready} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL after_reset_idle: vld=%b wr=%b busy=%b rdy=%b required 0 0 0 1",
                  mif.rsp_valid, mif.mem_write, mif.busy, mif.req_ready);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst_n           = 1'b0;
      mif.req_valid   = 1'b0;
      mif.req_store   = 1'b0;
      mif.req_funct   = 4'h0;
      mif.req_addr    = 32'h0;
      mif.req_wdata   = 32'h0;
      mif.mem_ack     = 1'b0;
      mif.mem_message = 32'h0;
      mif.rsp_ready   = 1'b0;

      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid_bus();
      test_directed();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
